// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: registered one-hot grant plus binary index, held until the owner
// releases, drops its request, or exceeds MAX_HOLD cycles. One idle bubble between grants.
module rr_arbiter8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDXW     = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HoldLast = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDXW:0] NumReq = (IDXW + 1)'(N);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] ptr_q;
  logic [CW-1:0]   hold_cnt_q;
  logic            timeout_q;

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] ptr_nxt;
  logic [IDXW:0]   idx_inc;
  logic            owner_rel;
  logic            time_rel;

  // Scan requesters starting at ptr_q, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    logic [N-1:0] req_sh;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    req_sh     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      req_sh = req >> cand;
      if (!pick_found && req_sh[0]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(cand);
      end
    end
  end

  always_comb begin
    idx_inc = {1'b0, idx_q} + (IDXW + 1)'(1);
    ptr_nxt = (idx_inc == NumReq) ? '0 : idx_inc[IDXW-1:0];
  end

  assign owner_rel = done | ~|(req & grant_q);
  assign time_rel  = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timeout_q <= 1'b0;
          if (pick_found) begin
            grant_q    <= N'(1) << pick_idx;
            idx_q      <= pick_idx;
            hold_cnt_q <= '0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (owner_rel || time_rel) begin
            grant_q   <= '0;
            ptr_q     <= ptr_nxt;
            state_q   <= StIdle;
            // An owner-initiated release in the same cycle suppresses the timeout flag.
            timeout_q <= time_rel & ~owner_rel;
          end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
            timeout_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic against a
// rule-level reference model of the round-robin arbiter.
module tb_rr_arbiter8;

  localparam int N        = 8;
  localparam int MAX_HOLD = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         grant_valid;
  logic         timeout;

  int tests = 0;
  int fails = 0;

  // Reference model state: who owns the resource, for how long, and who is first in line.
  bit m_busy;
  bit m_to;
  int m_idx;
  int m_ptr;
  int m_age;

  rr_arbiter8 #(.N(N), .IDXW(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_to   = 0;
    m_idx  = 0;
    m_ptr  = 0;
    m_age  = 0;
  endtask

  task automatic model_step();
    bit rel_owner, rel_time, found;
    m_to = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && req[c]) begin
          found  = 1;
          m_busy = 1;
          m_idx  = c;
          m_age  = 0;
        end
      end
    end else begin
      m_age++;
      rel_owner = done || !req[m_idx];
      rel_time  = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
      if (rel_owner || rel_time) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % N;
        m_to   = rel_time && !rel_owner;
      end
    end
  endtask

  task automatic check_model();
    check("grant", {24'd0, grant}, m_busy ? (32'd1 << m_idx) : 32'd0);
    check("grant_idx", {29'd0, grant_idx}, m_idx);
    check("grant_valid", {31'd0, grant_valid}, {31'd0, m_busy});
    check("timeout", {31'd0, timeout}, {31'd0, m_to});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!grant_valid && n < 20) begin
      cycle();
      n++;
    end
    check("wait_grant", {31'd0, grant_valid}, 32'd1);
  endtask

  initial begin
    int n;
    int cnt;

    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    #12;
    check("rst_grant", {24'd0, grant}, 32'd0);
    check("rst_idx", {29'd0, grant_idx}, 32'd0);
    check("rst_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single requester, one-cycle latency, release by done.
    req = 8'h01;
    cycle();
    check("first_grant", {24'd0, grant}, 32'h01);
    done = 1'b1;
    cycle();
    done = 1'b0;
    check("done_release", {31'd0, grant_valid}, 32'd0);

    // All requesting: strict rotation with exactly one idle cycle between grants.
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      wait_grant(n);
      check("rr_gap", n, 32'd1);
      check("rr_seq", {29'd0, grant_idx}, g % 8);
      cycle();
      done = 1'b1;
      cycle();
      done = 1'b0;
      check("rr_bubble", {31'd0, grant_valid}, 32'd0);
    end

    // Pointer at 6 must wrap past 6,7 to requester 0 rather than going back to 5.
    do_reset();
    req = 8'h20;
    wait_grant(n);
    check("grant5", {29'd0, grant_idx}, 32'd5);
    done = 1'b1;
    cycle();
    done = 1'b0;
    req = 8'h21;
    wait_grant(n);
    check("wrap", {29'd0, grant_idx}, 32'd0);
    done = 1'b1;
    cycle();
    done = 1'b0;

    // Hold-time limit.
    do_reset();
    req = 8'h08;
    wait_grant(n);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!grant_valid) break;
      cnt++;
    end
    check("hold_len", cnt, MAX_HOLD);
    check("timeout_pulse", {31'd0, timeout}, 32'd1);
    cycle();
    check("timeout_end", {31'd0, timeout}, 32'd0);
    wait_grant(n);
    check("regrant_self", {29'd0, grant_idx}, 32'd3);
    req = 8'h18;
    for (int i = 0; i < 40 && grant_valid; i++) cycle();
    wait_grant(n);
    check("regrant_next", {29'd0, grant_idx}, 32'd4);

    // done coinciding with the hold limit is a plain release.
    do_reset();
    req = 8'h08;
    wait_grant(n);
    repeat (MAX_HOLD - 1) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    check("done_vs_timeout", {31'd0, timeout}, 32'd0);
    check("done_vs_timeout_valid", {31'd0, grant_valid}, 32'd0);

    // Owner drops its request.
    do_reset();
    req = 8'h04;
    wait_grant(n);
    req = 8'h00;
    cycle();
    check("drop_valid", {31'd0, grant_valid}, 32'd0);
    check("drop_timeout", {31'd0, timeout}, 32'd0);
    req = 8'hFF;
    wait_grant(n);
    check("ptr_after_drop", {29'd0, grant_idx}, 32'd3);

    // Asynchronous reset between edges while a grant is active.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_grant", {24'd0, grant}, 32'd0);
    check("async_valid", {31'd0, grant_valid}, 32'd0);
    check("async_timeout", {31'd0, timeout}, 32'd0);
    model_reset();
    req = 8'h81;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(n);
    check("ptr_restart", {29'd0, grant_idx}, 32'd0);
    done = 1'b1;
    cycle();
    done = 1'b0;
    req = 8'h80;
    wait_grant(n);
    check("grant7", {29'd0, grant_idx}, 32'd7);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      done = ($urandom_range(0, 5) == 0);
      cycle();
    end
    done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one resource between N requesters, default 8.
- Each requester presents a request bit. The block issues a registered one-hot grant and its 3-bit binary index, so downstream muxing needs no separate encoder.
- The grant is held until the owner releases it, drops its request, or exceeds a hold-time limit. Fairness comes from a rotating priority pointer.

Parameters:
- N, 8, number of requesters; legal range 2..8.
- IDXW, 3, width of grant_idx; must satisfy 2**IDXW >= N.
- MAX_HOLD, 16, maximum cycles one owner may hold the grant; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit i = requester i wants the resource.
- done  input  1  single-cycle release strobe from the current owner.
- grant  output  N  one-hot grant vector, registered.
- grant_idx  output  IDXW  binary index of the granted requester, registered.
- grant_valid  output  1  high while any grant is active; equals |grant.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async assert, sync release): grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- ptr (IDXW bits) holds the highest-priority index. Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Modulo N wrap applies for any N, not only powers of two.
- State IDLE:
  - If req != 0 at edge k, select the first set bit in search order.
  - grant, grant_idx and grant_valid are updated at edge k (visible in cycle k+1). hold_cnt=0; go to BUSY.
  - Latency from req asserted to grant visible: 1 cycle.
  - If req == 0, stay IDLE; outputs remain 0.
- State BUSY:
  - grant and grant_idx are stable; hold_cnt increments every cycle.
  - A release event occurs on any of:
    - (a) done=1;
    - (b) req[grant_idx]=0;
    - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
  - On release at edge k: grant=0, grant_valid=0, ptr=(grant_idx+1) mod N, go to IDLE.
  - If (c) applies and neither (a) nor (b) applies in the same cycle, timeout=1 for exactly cycle k+1.
- Mandatory IDLE cycle: grant_valid is low for at least one cycle between any two grants, including back-to-back requests. This gives a turnaround bubble for the shared resource.
- grant_idx holds its last value while grant_valid=0. Consumers must qualify it with grant_valid.
- done while IDLE is ignored. Requests from non-owners while BUSY are ignored; they do not pre-empt.
- Simultaneous done and timeout in the same cycle: treated as a normal release, timeout stays 0.
- Reset mid-grant: outputs clear immediately and asynchronously; ptr returns to 0.
- Invariants: grant is always zero or one-hot; grant_valid == |grant; when grant_valid=1, grant[grant_idx]=1.

Test Plan:
- Reset, then req=8'b00000001: grant=8'b00000001, grant_idx=0, grant_valid=1 one cycle after req. Pulse done: grant=0 next cycle, ptr=1.
- req=8'hFF held, done pulsed 2 cycles after each grant: grant_idx sequence is 0,1,2,...,7,0. Every grant is separated by exactly one grant_valid=0 cycle.
- ptr=6 (after granting 5), req=8'b00100001: grant_idx=0 (wrap past 6,7), not 5.
- MAX_HOLD=16, req[3] held, no done: grant held exactly 16 cycles. Then grant drops and timeout=1 for one cycle. Next grant goes to the next requester after 3 if one is requesting, else back to 3.
- Owner 2 drops req[2] while BUSY, no done: grant clears next cycle, timeout=0, ptr=3.
- Assert rst_n=0 mid-grant between clock edges: grant, grant_valid and timeout go 0 immediately. After release, req=8'h80 yields grant_idx=7 with ptr restarted at 0.
